// File: rtl/wb_write_queue.sv
// Writeback queue: buffers register-file writes in FIFO order behind a single
// write port and answers pending-write lookups for the youngest queued value.
module wb_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       inValid,
    output logic                       inReady,
    input  logic [4:0]                 inReg,
    input  logic [31:0]                inData,
    input  logic                       drainHold,
    output logic                       regWrite,
    output logic [4:0]                 writeReg,
    output logic [31:0]                writeData,
    input  logic [4:0]                 lookReg1,
    input  logic [4:0]                 lookReg2,
    output logic                       lookHit1,
    output logic                       lookHit2,
    output logic [31:0]                lookData1,
    output logic [31:0]                lookData2,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    regMem  [DEPTH];
    logic [31:0]   dataMem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          doEnq;
    logic          doPop;
    logic [PW-1:0] idx;

    assign empty    = (count == '0);
    assign inReady  = (count != CW'(DEPTH));
    assign regWrite = !empty && !drainHold;
    assign doPop    = regWrite;
    // Writes to r0 complete the handshake but never occupy a slot.
    assign doEnq    = inValid && inReady && (inReg != 5'd0);

    assign writeReg  = empty ? 5'd0  : regMem[head];
    assign writeData = empty ? 32'd0 : dataMem[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (doEnq) tail <= tail + PW'(1);
            if (doPop) head <= head + PW'(1);
            if (doEnq && !doPop)
                count <= count + CW'(1);
            else if (doPop && !doEnq)
                count <= count - CW'(1);
        end
    end

    // Entry storage is deliberately left unreset; count gates visibility.
    always_ff @(posedge clk) begin
        if (doEnq) begin
            regMem[tail]  <= inReg;
            dataMem[tail] <= inData;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        lookHit1  = 1'b0;
        lookHit2  = 1'b0;
        lookData1 = 32'd0;
        lookData2 = 32'd0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count) begin
                if (lookReg1 != 5'd0 && regMem[idx] == lookReg1) begin
                    lookHit1  = 1'b1;
                    lookData1 = dataMem[idx];
                end
                if (lookReg2 != 5'd0 && regMem[idx] == lookReg2) begin
                    lookHit2  = 1'b1;
                    lookData2 = dataMem[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue with a queue-based scoreboard of expected
// register-file writes, checked every cycle at the falling edge.
module tb_wb_write_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [4:0]  inReg;
    logic [31:0] inData;
    logic        drainHold;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [4:0]  lookReg1;
    logic [4:0]  lookReg2;
    logic        lookHit1;
    logic        lookHit2;
    logic [31:0] lookData1;
    logic [31:0] lookData2;
    logic        empty;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    logic [36:0] sb[$];

    wb_write_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .inValid(inValid), .inReady(inReady), .inReg(inReg), .inData(inData),
        .drainHold(drainHold),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .lookReg1(lookReg1), .lookReg2(lookReg2),
        .lookHit1(lookHit1), .lookHit2(lookHit2),
        .lookData1(lookData1), .lookData2(lookData2),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] modelLook(input logic [4:0] r);
        logic [32:0] res;
        res = 33'd0;
        if (r != 5'd0)
            for (int i = 0; i < sb.size(); i++)
                if (sb[i][36:32] == r) res = {1'b1, sb[i][31:0]};
        return res;
    endfunction

    // One clock cycle: compare everything against the model at the falling
    // edge, then advance the model by what the next rising edge will do.
    task automatic applyStimulus();
        logic        expWrite;
        logic        enq;
        logic [32:0] l1;
        logic [32:0] l2;
        @(negedge clk);
        expWrite = (sb.size() != 0) && !drainHold;
        checkOutput("count", 32'(count), 32'(sb.size()));
        checkOutput("empty", 32'(empty), 32'(sb.size() == 0));
        checkOutput("inReady", 32'(inReady), 32'(sb.size() != DEPTH));
        checkOutput("regWrite", 32'(regWrite), 32'(expWrite));
        if (sb.size() != 0) begin
            checkOutput("writeReg", 32'(writeReg), 32'(sb[0][36:32]));
            checkOutput("writeData", writeData, sb[0][31:0]);
        end else begin
            checkOutput("writeRegIdle", 32'(writeReg), 32'd0);
            checkOutput("writeDataIdle", writeData, 32'd0);
        end
        l1 = modelLook(lookReg1);
        l2 = modelLook(lookReg2);
        checkOutput("lookHit1", 32'(lookHit1), 32'(l1[32]));
        checkOutput("lookData1", lookData1, l1[31:0]);
        checkOutput("lookHit2", 32'(lookHit2), 32'(l2[32]));
        checkOutput("lookData2", lookData2, l2[31:0]);
        enq = inValid && (sb.size() < DEPTH) && (inReg != 5'd0);
        if (expWrite) void'(sb.pop_front());
        if (enq) sb.push_back({inReg, inData});
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] r, input logic [31:0] d);
        inValid = 1'b1;
        inReg   = r;
        inData  = d;
        applyStimulus();
        inValid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; inValid = 1'b0; inReg = '0; inData = '0;
        drainHold = 1'b0; lookReg1 = '0; lookReg2 = '0;
        #2;
        checkOutput("rstEmpty", 32'(empty), 32'd1);
        checkOutput("rstInReady", 32'(inReady), 32'd1);
        checkOutput("rstRegWrite", 32'(regWrite), 32'd0);
        checkOutput("rstLookHit1", 32'(lookHit1), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus();

        // Single write, one-cycle latency
        offer(5'd5, 32'h1234);
        checkOutput("latRegWrite", 32'(regWrite), 32'd1);
        checkOutput("latWriteReg", 32'(writeReg), 32'd5);
        checkOutput("latWriteData", writeData, 32'h1234);
        applyStimulus();
        checkOutput("latEmptyAfter", 32'(empty), 32'd1);
        applyStimulus();

        // Fill under hold, refuse fifth, then drain in order
        drainHold = 1'b1;
        lookReg1 = 5'd2; lookReg2 = 5'd4;
        offer(5'd1, 32'h11);
        offer(5'd2, 32'h22);
        offer(5'd3, 32'h33);
        offer(5'd4, 32'h44);
        checkOutput("fullCount", 32'(count), 32'd4);
        checkOutput("fullInReady", 32'(inReady), 32'd0);
        offer(5'd6, 32'h66);
        drainHold = 1'b0;
        repeat (5) applyStimulus();

        // Full queue: enqueue refused on the popping cycle, accepted next
        drainHold = 1'b1;
        offer(5'd10, 32'hA0);
        offer(5'd11, 32'hB0);
        offer(5'd12, 32'hC0);
        offer(5'd13, 32'hD0);
        drainHold = 1'b0;
        offer(5'd9, 32'h99);
        checkOutput("popRefuseCount", 32'(count), 32'd3);
        offer(5'd9, 32'h99);
        checkOutput("popAcceptCount", 32'(count), 32'd3);
        repeat (4) applyStimulus();

        // Lookups return youngest match
        drainHold = 1'b1;
        lookReg1 = 5'd0; lookReg2 = 5'd0;
        offer(5'd7, 32'hA);
        offer(5'd3, 32'hB);
        offer(5'd7, 32'hC);
        lookReg1 = 5'd7; lookReg2 = 5'd3;
        #1;
        checkOutput("look7Hit", 32'(lookHit1), 32'd1);
        checkOutput("look7Data", lookData1, 32'hC);
        checkOutput("look3Hit", 32'(lookHit2), 32'd1);
        checkOutput("look3Data", lookData2, 32'hB);
        lookReg1 = 5'd0;
        #1;
        checkOutput("look0Hit", 32'(lookHit1), 32'd0);
        checkOutput("look0Data", lookData1, 32'd0);
        lookReg1 = 5'd7;
        drainHold = 1'b0;
        repeat (4) applyStimulus();

        // r0 writes are swallowed
        offer(5'd0, 32'hFFFF);
        checkOutput("r0Count", 32'(count), 32'd0);
        checkOutput("r0RegWrite", 32'(regWrite), 32'd0);
        applyStimulus();

        // Reset mid-operation discards queued entries
        drainHold = 1'b1;
        offer(5'd20, 32'h200);
        offer(5'd21, 32'h210);
        offer(5'd22, 32'h220);
        drainHold = 1'b0;
        rst_n = 1'b0;
        #2;
        checkOutput("midRstCount", 32'(count), 32'd0);
        checkOutput("midRstRegWrite", 32'(regWrite), 32'd0);
        sb.delete();
        #1;
        rst_n = 1'b1;
        repeat (3) applyStimulus();
        offer(5'd8, 32'h88);
        repeat (2) applyStimulus();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
